// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int unsigned NUM_SRC_DEF = 4;
    localparam int unsigned SRC_W       = $clog2(NUM_SRC_DEF);
    localparam int unsigned MAX_SRC     = 8;
    localparam int unsigned IDX_W       = 3;

    // One-hot vector (up to MAX_SRC wide) to binary index; 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_SRC-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_rr_pkt_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after ptr, wrapping at N.
module rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             found
);

    // Search ptr+1, ptr+2, ... ptr+N (mod N); the first set request wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!found && req[PTR_W'((32'(ptr) + k) % N)]) begin
                pick[PTR_W'((32'(ptr) + k) % N)] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered AXI-Stream output.
// Optional macro AXIS_ARB_SRC_ID_EN adds m_src_id, the source index of the beat in m_*.
module axis_rr_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*DATA_W-1:0]   s_data,
    input  logic [NUM_SRC-1:0]          s_valid,
    input  logic [NUM_SRC-1:0]          s_last,
    output logic [NUM_SRC-1:0]          s_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic [NUM_SRC-1:0]          grant,
    output logic                        busy
`ifdef AXIS_ARB_SRC_ID_EN
    ,
    output logic [$clog2(NUM_SRC)-1:0]  m_src_id
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_SRC);

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_SRC-1:0]  pick;
    logic                found;
    logic [PTR_W-1:0]    pick_idx;
    logic                out_free;
    logic                accept;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;

    rr_picker #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (s_valid),
        .ptr   (rr_ptr),
        .pick  (pick),
        .found (found)
    );

    assign pick_idx = PTR_W'(onehot2idx(MAX_SRC'(pick)));

    // While a packet is granted rr_ptr holds the owner's index, so it doubles as the mux select.
    assign sel_valid = s_valid[rr_ptr];
    assign sel_last  = s_last[rr_ptr];
    assign sel_data  = s_data[rr_ptr*DATA_W +: DATA_W];

    // Output register can take a beat when empty or draining this cycle.
    assign out_free = !m_valid || m_ready;
    assign s_ready  = grant & {NUM_SRC{out_free}};
    assign accept   = (state == XFER) && sel_valid && out_free;

    // FSM, round-robin pointer, grant and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= PTR_W'(NUM_SRC - 1);
            grant   <= '0;
            busy    <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
`ifdef AXIS_ARB_SRC_ID_EN
            m_src_id <= '0;
`endif
        end else begin
            if (m_valid && m_ready && !accept) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant  <= pick;
                        rr_ptr <= pick_idx;
                        busy   <= 1'b1;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        m_data  <= sel_data;
                        m_last  <= sel_last;
                        m_valid <= 1'b1;
`ifdef AXIS_ARB_SRC_ID_EN
                        m_src_id <= rr_ptr;
`endif
                        if (sel_last) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Directed self-checking bench for axis_rr_pkt_arbiter (NUM_SRC=4, DATA_W=8).
module tb_axis_rr_pkt_arbiter;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 32;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_SRC*DATA_W-1:0] s_data  = '0;
    logic [NUM_SRC-1:0]        s_valid = '0;
    logic [NUM_SRC-1:0]        s_last  = '0;
    logic [NUM_SRC-1:0]        s_ready;
    logic [DATA_W-1:0]         m_data;
    logic                      m_valid;
    logic                      m_last;
    logic                      m_ready = 1'b1;
    logic [NUM_SRC-1:0]        grant;
    logic                      busy;
`ifdef AXIS_ARB_SRC_ID_EN
    logic [$clog2(NUM_SRC)-1:0] m_src_id;
`endif

    axis_rr_pkt_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .grant   (grant),
        .busy    (busy)
`ifdef AXIS_ARB_SRC_ID_EN
        ,
        .m_src_id (m_src_id)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-source beat FIFOs: mem/tail written by the test, head by the source driver.
    logic [DATA_W:0] mem [NUM_SRC][DEPTH];
    int              head [NUM_SRC] = '{default: 0};
    int              tail [NUM_SRC] = '{default: 0};
    logic [NUM_SRC-1:0] hs;
    logic               rst_seen;

    logic [DATA_W-1:0] got_q [$];
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // AXI-Stream source model: pops a beat on each handshake, presents the FIFO head.
    always begin
        @(posedge clk);
        hs       = s_valid & s_ready;
        rst_seen = rst;
        #2;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst_seen && hs[i] && head[i] != tail[i]) head[i]++;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            s_valid[i]                 = (head[i] != tail[i]);
            s_data[i*DATA_W +: DATA_W] = mem[i][head[i] % DEPTH][DATA_W-1:0];
            s_last[i]                  = mem[i][head[i] % DEPTH][DATA_W];
        end
    end

    // Record every beat that leaves m_*.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back(m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int src, input logic [DATA_W-1:0] d, input logic l);
        mem[src][tail[src] % DEPTH] = {l, d};
        tail[src]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            tick();
            done = !m_valid && !busy;
            for (int i = 0; i < NUM_SRC; i++) if (head[i] != tail[i]) done = 0;
        end
        if (!done) chk({tag, "_timeout"}, 32'(1), 32'(0));
    endtask

    task automatic check_seq(input string tag, input int base);
        chk({tag, "_len"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(got_q[base+i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        int base;
        do_reset();

        // reset state
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data",  32'(m_data),  32'(0));
        chk("rst_m_last",  32'(m_last),  32'(0));
        chk("rst_grant",   32'(grant),   32'(0));
        chk("rst_busy",    32'(busy),    32'(0));
        chk("rst_s_ready", 32'(s_ready), 32'(0));

        // 1: single source, 3 beats, latency and m_last placement
        base = got_q.size();
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        tick();
        chk("t1_grant",   32'(grant),   32'(4'b0001));
        chk("t1_busy",    32'(busy),    32'(1));
        chk("t1_mv0",     32'(m_valid), 32'(0));
        #3;
        chk("t1_s_ready", 32'(s_ready), 32'(4'b0001));
        tick();
        chk("t1_d1", 32'(m_data), 32'(8'hA1)); chk("t1_v1", 32'(m_valid), 32'(1)); chk("t1_l1", 32'(m_last), 32'(0));
        tick();
        chk("t1_d2", 32'(m_data), 32'(8'hA2)); chk("t1_l2", 32'(m_last), 32'(0));
        tick();
        chk("t1_d3", 32'(m_data), 32'(8'hA3)); chk("t1_l3", 32'(m_last), 32'(1));
        chk("t1_grant_end", 32'(grant), 32'(0));
        tick();
        chk("t1_mv_end", 32'(m_valid), 32'(0));
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        check_seq("t1_seq", base);

        // 2: all four sources request at once from reset -> 0,1,2,3,0
        do_reset();
        base = got_q.size();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
        wait_idle("t2");
        exp_q = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
        check_seq("t2_seq", base);

        // 3: source 2 blocked while source 1 owns the output (rr_ptr now 0)
        base = got_q.size();
        push(1, 8'h15, 1'b0); push(1, 8'h16, 1'b0); push(1, 8'h17, 1'b1);
        tick();
        chk("t3_grant1", 32'(grant), 32'(4'b0010));
        push(2, 8'h25, 1'b0); push(2, 8'h26, 1'b1);
        #3;
        chk("t3_s_ready_a", 32'(s_ready), 32'(4'b0010));
        tick();
        tick();
        #3;
        chk("t3_s_ready_b", 32'(s_ready[2]), 32'(0));
        tick();
        chk("t3_idle_grant", 32'(grant), 32'(0));
        chk("t3_idle_busy",  32'(busy),  32'(0));
        #3;
        chk("t3_idle_s_ready", 32'(s_ready), 32'(0));
        tick();
        chk("t3_grant2", 32'(grant), 32'(4'b0100));
        wait_idle("t3");
        exp_q = '{8'h15, 8'h16, 8'h17, 8'h25, 8'h26};
        check_seq("t3_seq", base);

        // 4: downstream stall of 4 cycles mid-packet
        base = got_q.size();
        push(3, 8'h35, 1'b0); push(3, 8'h36, 1'b0); push(3, 8'h37, 1'b0); push(3, 8'h38, 1'b1);
        tick();
        chk("t4_grant", 32'(grant), 32'(4'b1000));
        tick();
        tick();
        m_ready = 1'b0;
        #3;
        chk("t4_s_ready", 32'(s_ready), 32'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t4_hold_d%0d", i), 32'(m_data),  32'(8'h36));
            chk($sformatf("t4_hold_v%0d", i), 32'(m_valid), 32'(1));
        end
        m_ready = 1'b1;
        wait_idle("t4");
        exp_q = '{8'h35, 8'h36, 8'h37, 8'h38};
        check_seq("t4_seq", base);

        // 5: reset on beat 2 of a 4-beat packet, then pointer back to NUM_SRC-1
        push(2, 8'h51, 1'b0); push(2, 8'h52, 1'b0); push(2, 8'h53, 1'b0); push(2, 8'h54, 1'b1);
        tick();
        tick();
        tick();
        chk("t5_pre_d", 32'(m_data), 32'(8'h52));
        rst = 1'b1;
        tick();
        chk("t5_m_valid", 32'(m_valid), 32'(0));
        chk("t5_m_data",  32'(m_data),  32'(0));
        chk("t5_m_last",  32'(m_last),  32'(0));
        chk("t5_grant",   32'(grant),   32'(0));
        chk("t5_busy",    32'(busy),    32'(0));
        for (int i = 0; i < NUM_SRC; i++) tail[i] = head[i];
        rst = 1'b0;
        base = got_q.size();
        push(0, 8'h61, 1'b1);
        push(3, 8'h71, 1'b1);
        tick();
        chk("t5_winner", 32'(grant), 32'(4'b0001));
        wait_idle("t5");
        exp_q = '{8'h61, 8'h71};
        check_seq("t5_seq", base);

`ifdef AXIS_ARB_SRC_ID_EN
        // 6: source index travels with each beat
        begin
            int seen = 0;
            push(3, 8'h81, 1'b0); push(3, 8'h82, 1'b1);
            tick();
            push(0, 8'h91, 1'b1);
            for (int n = 0; n < 20; n++) begin
                if (m_valid) begin
                    seen++;
                    chk($sformatf("t6_id_%0h", m_data), 32'(m_src_id), (m_data[7:4] == 4'h8) ? 32'(3) : 32'(0));
                end
                tick();
            end
            chk("t6_beats", 32'(seen), 32'(3));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
